// File: rtl/lse_pkg.sv
// Shared types and constants for the log-space SIMD multiplier pipeline.
package lse_pkg;

    localparam int DATA_W    = 24;
    localparam int LANE_W_1X = 24;
    localparam int LANE_W_2X = 12;
    localparam int LANE_W_4X = 6;

    typedef enum logic [1:0] {
        MODE_1X24    = 2'b00,
        MODE_2X12    = 2'b01,
        MODE_4X6     = 2'b10,
        MODE_ILLEGAL = 2'b11
    } simd_mode_e;

    // Raw lane sums, each one bit wider than its lane so the carry-out survives.
    typedef struct packed {
        logic [LANE_W_1X:0]            s24;
        logic [1:0][LANE_W_2X:0]       s12;
        logic [3:0][LANE_W_4X:0]       s6;
    } lane_sums_t;

    // Lanes that exist in a given mode; the illegal mode computes as one 24-bit lane.
    function automatic logic [3:0] lane_ovf_mask(input simd_mode_e mode);
        case (mode)
            MODE_2X12: return 4'b0011;
            MODE_4X6:  return 4'b1111;
            default:   return 4'b0001;
        endcase
    endfunction

endpackage

// File: rtl/lse_lane_sat.sv
// Selects the active lane sums for the mode and saturates or wraps each lane.
module lse_lane_sat
    import lse_pkg::*;
#(
    parameter int SAT_EN = 1
) (
    input  lane_sums_t        sums,
    input  simd_mode_e        mode,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        lane_ovf
);

    logic [3:0] carry;

    // Per-lane carry extraction and saturate/wrap selection.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        carry  = '0;
        result = '0;
        case (mode)
            MODE_2X12: begin
                for (int k = 0; k < 2; k++) begin
                    carry[k] = sums.s12[k][LANE_W_2X];
                    result[k*LANE_W_2X +: LANE_W_2X] = ((SAT_EN != 0) && carry[k])
                        ? '1 : sums.s12[k][LANE_W_2X-1:0];
                end
            end
            MODE_4X6: begin
                for (int k = 0; k < 4; k++) begin
                    carry[k] = sums.s6[k][LANE_W_4X];
                    result[k*LANE_W_4X +: LANE_W_4X] = ((SAT_EN != 0) && carry[k])
                        ? '1 : sums.s6[k][LANE_W_4X-1:0];
                end
            end
            default: begin
                carry[0] = sums.s24[LANE_W_1X];
                result   = ((SAT_EN != 0) && carry[0]) ? '1 : sums.s24[LANE_W_1X-1:0];
            end
        endcase
        lane_ovf = carry & lane_ovf_mask(mode);
    end

endmodule

// File: rtl/lse_mult_simd_pipe.sv
// Two-stage valid/ready pipeline around the SIMD lane adder with an overflow-event counter.
module lse_mult_simd_pipe
    import lse_pkg::*;
#(
    parameter int SAT_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [1:0]        simd_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        lane_ovf,
    output logic              mode_err,
    input  logic              ovf_clr,
    output logic [CNT_W-1:0]  ovf_count
);

    logic              s1_valid;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    simd_mode_e        s1_mode;
    logic              s1_adv;
    logic              s2_adv;
    logic              deliver;
    lane_sums_t        sums;
    logic [DATA_W-1:0] sat_result;
    logic [3:0]        sat_ovf;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = s2_adv || !s1_valid;
    assign in_ready = s1_adv;
    assign deliver  = out_valid && out_ready;

    // Stage-1 occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
        end
    end

    // Stage-1 operand capture.
    // NOTE: pure data registers qualified by s1_valid need no reset.
    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_a    <= operand_a;
            s1_b    <= operand_b;
            s1_mode <= simd_mode_e'(simd_mode);
        end
    end

    // Lane sums for every lane width; the mode picks which set is used.
    always_comb begin
        sums     = '0;
        sums.s24 = {1'b0, s1_a} + {1'b0, s1_b};
        for (int k = 0; k < 2; k++) begin
            sums.s12[k] = {1'b0, s1_a[k*LANE_W_2X +: LANE_W_2X]}
                        + {1'b0, s1_b[k*LANE_W_2X +: LANE_W_2X]};
        end
        for (int k = 0; k < 4; k++) begin
            sums.s6[k] = {1'b0, s1_a[k*LANE_W_4X +: LANE_W_4X]}
                       + {1'b0, s1_b[k*LANE_W_4X +: LANE_W_4X]};
        end
    end

    lse_lane_sat #(.SAT_EN(SAT_EN)) u_lane_sat (
        .sums     (sums),
        .mode     (s1_mode),
        .result   (sat_result),
        .lane_ovf (sat_ovf)
    );

    // Stage-2 output register; holds while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            lane_ovf  <= '0;
            mode_err  <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result   <= sat_result;
                lane_ovf <= sat_ovf;
                mode_err <= (s1_mode == MODE_ILLEGAL);
            end
        end
    end

    // Saturating count of delivered beats with any lane overflow; clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (ovf_clr) begin
            ovf_count <= '0;
        end else if (deliver && (|lane_ovf) && (ovf_count != '1)) begin
            ovf_count <= ovf_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_lse_mult_simd_pipe.sv
// Directed bench: one saturating and one wrapping instance driven in lockstep.
module tb_lse_mult_simd_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [23:0] operand_a;
    logic [23:0] operand_b;
    logic [1:0]  simd_mode;
    logic        out_ready;
    logic        ovf_clr;

    logic        in_ready_s, in_ready_w;
    logic        out_valid_s, out_valid_w;
    logic [23:0] result_s, result_w;
    logic [3:0]  lane_ovf_s, lane_ovf_w;
    logic        mode_err_s, mode_err_w;
    logic [15:0] ovf_count_s, ovf_count_w;

    int n_vec = 0;
    int n_err = 0;

    logic [23:0] bp_a   [6] = '{24'h111111, 24'h222222, 24'h333333,
                                24'h444444, 24'h555555, 24'h666666};
    logic [23:0] bp_exp [6] = '{24'h121212, 24'h232323, 24'h343434,
                                24'h454545, 24'h565656, 24'h676767};

    lse_mult_simd_pipe #(.SAT_EN(1), .CNT_W(16)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .operand_a(operand_a), .operand_b(operand_b), .simd_mode(simd_mode),
        .out_valid(out_valid_s), .out_ready(out_ready), .result(result_s),
        .lane_ovf(lane_ovf_s), .mode_err(mode_err_s), .ovf_clr(ovf_clr),
        .ovf_count(ovf_count_s)
    );

    lse_mult_simd_pipe #(.SAT_EN(0), .CNT_W(16)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .operand_a(operand_a), .operand_b(operand_b), .simd_mode(simd_mode),
        .out_valid(out_valid_w), .out_ready(out_ready), .result(result_w),
        .lane_ovf(lane_ovf_w), .mode_err(mode_err_w), .ovf_clr(ovf_clr),
        .ovf_count(ovf_count_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Single beat with out_ready high; starts and ends just after a rising edge.
    task automatic run_beat(input string tag, input logic [23:0] a, input logic [23:0] b,
                            input logic [1:0] mode, input logic [23:0] exp_sat,
                            input logic [23:0] exp_wrap, input logic [3:0] exp_ovf,
                            input logic exp_err, input logic clr, input logic [15:0] exp_cnt);
        in_valid  = 1'b1;
        operand_a = a;
        operand_b = b;
        simd_mode = mode;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready_s, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_lat1_valid"}, out_valid_s, 0);
        @(posedge clk); #1;
        check({tag, "_lat2_valid_s"}, out_valid_s, 1);
        check({tag, "_lat2_valid_w"}, out_valid_w, 1);
        check({tag, "_result_sat"}, result_s, exp_sat);
        check({tag, "_result_wrap"}, result_w, exp_wrap);
        check({tag, "_ovf_s"}, lane_ovf_s, exp_ovf);
        check({tag, "_ovf_w"}, lane_ovf_w, exp_ovf);
        check({tag, "_err_s"}, mode_err_s, exp_err);
        check({tag, "_err_w"}, mode_err_w, exp_err);
        ovf_clr = clr;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check({tag, "_drained"}, out_valid_s, 0);
        check({tag, "_cnt_s"}, ovf_count_s, exp_cnt);
        check({tag, "_cnt_w"}, ovf_count_w, exp_cnt);
    endtask

    int sent;
    int rcv;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        operand_a = '0;
        operand_b = '0;
        simd_mode = 2'b00;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        #1;
        check("rst_out_valid", out_valid_s, 0);
        check("rst_in_ready", in_ready_s, 1);
        check("rst_result", result_s, 0);
        check("rst_lane_ovf", lane_ovf_s, 0);
        check("rst_mode_err", mode_err_s, 0);
        check("rst_ovf_count", ovf_count_s, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Mode 00 plain add.
        run_beat("m00", 24'h000001, 24'h000002, 2'b00, 24'h000003, 24'h000003, 4'b0000, 0, 0, 16'd0);
        // Mode 01 lane-0 carry.
        run_beat("m01_l0", 24'h001FFF, 24'h002001, 2'b01, 24'h003FFF, 24'h003000, 4'b0001, 0, 0, 16'd1);
        // Mode 10 lane-0 carry, must not reach lane 1.
        run_beat("m10_l0", 24'h00003F, 24'h000041, 2'b10, 24'h00007F, 24'h000040, 4'b0001, 0, 0, 16'd2);
        // Mode 10 lane-1 carry only.
        run_beat("m10_l1", 24'hFFFFFF, 24'h000040, 2'b10, 24'hFFFFFF, 24'hFFF03F, 4'b0010, 0, 0, 16'd3);
        // Mode 01 lane-1 carry only.
        run_beat("m01_l1", 24'hFFF000, 24'h001000, 2'b01, 24'hFFF000, 24'h000000, 4'b0010, 0, 0, 16'd4);
        // Illegal mode, overflowing, with clear on the same delivery.
        run_beat("m11_clr", 24'hFFFFFF, 24'h000001, 2'b11, 24'hFFFFFF, 24'h000000, 4'b0001, 1, 1, 16'd0);

        // Backpressure: six beats, out_ready low for the first five cycles.
        sent = 0;
        rcv  = 0;
        for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
            out_ready = (cyc >= 5);
            in_valid  = (sent < 6);
            if (sent < 6) begin
                operand_a = bp_a[sent];
                operand_b = 24'h010101;
                simd_mode = 2'b00;
            end
            @(negedge clk);
            if (cyc == 3) check("bp_hold_result", result_s, 24'h121212);
            if (cyc == 4) begin
                check("bp_in_ready_full", in_ready_s, 0);
                check("bp_beats_held", sent, 2);
            end
            if (out_valid_s && out_ready) begin
                check("bp_result_s", result_s, bp_exp[rcv]);
                check("bp_valid_w", out_valid_w, 1);
                check("bp_result_w", result_w, bp_exp[rcv]);
                rcv++;
            end
            if (in_valid && in_ready_s) sent++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_all_delivered", rcv, 6);
        check("bp_cnt", ovf_count_s, 0);

        // Reset with two beats in flight.
        run_beat("pre_rst", 24'h00003F, 24'h000041, 2'b10, 24'h00007F, 24'h000040, 4'b0001, 0, 0, 16'd1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        operand_a = 24'hFFFFFF;
        operand_b = 24'h000001;
        simd_mode = 2'b00;
        @(posedge clk); #1;
        operand_a = 24'h000010;
        operand_b = 24'h000020;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("inflight_valid", out_valid_s, 1);
        check("inflight_in_ready", in_ready_s, 0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid_s", out_valid_s, 0);
        check("async_rst_valid_w", out_valid_w, 0);
        check("async_rst_cnt", ovf_count_s, 0);
        check("async_rst_in_ready", in_ready_s, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        run_beat("post_rst", 24'h123456, 24'h111111, 2'b00, 24'h234567, 24'h234567, 4'b0000, 0, 0, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
